// File: rtl/tl_ad_channel_buffer.sv
// TileLink A/D channel buffer: one registered circular FIFO per channel,
// placed behind the 64-bit width widget to cut the ready/valid timing paths.
// Beats pass through unmodified and in strict order on each channel.

module tl_ad_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_enq_valid,
  output logic         o_enq_ready,
  input  logic [W-1:0] i_enq_bits,
  output logic         o_deq_valid,
  input  logic         i_deq_ready,
  output logic [W-1:0] o_deq_bits
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_maybe_full;

  logic w_ptr_match;
  logic w_empty;
  logic w_full;
  logic w_enq;
  logic w_deq;

  assign w_ptr_match = (r_wr_ptr == r_rd_ptr);
  assign w_empty     = w_ptr_match & ~r_maybe_full;
  assign w_full      = w_ptr_match & r_maybe_full;
  assign o_enq_ready = ~w_full;
  assign o_deq_valid = ~w_empty;
  assign w_enq       = i_enq_valid & ~w_full;
  assign w_deq       = i_deq_ready & ~w_empty;
  // Output comes straight from storage so bits stay put while stalled.
  assign o_deq_bits  = r_mem[r_rd_ptr];

  // Payload storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= i_enq_bits;
    end
  end

  // Pointer and occupancy tracking; explicit wrap handles non-power-of-2 depths.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_maybe_full <= 1'b0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_enq != w_deq) begin
        r_maybe_full <= w_enq;
      end
    end
  end
endmodule

module tl_ad_channel_buffer #(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter int ADDR_W  = 31,
  parameter int DATA_W  = 64,
  parameter int SRC_W   = 3,
  parameter int SIZE_W  = 4
) (
  input  logic                clock,
  input  logic                reset,
  // A channel from upstream
  output logic                auto_in_a_ready,
  input  logic                auto_in_a_valid,
  input  logic [2:0]          auto_in_a_bits_opcode,
  input  logic [2:0]          auto_in_a_bits_param,
  input  logic [SIZE_W-1:0]   auto_in_a_bits_size,
  input  logic [SRC_W-1:0]    auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
  input  logic [DATA_W/8-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_a_bits_data,
  input  logic                auto_in_a_bits_corrupt,
  // D channel toward upstream
  input  logic                auto_in_d_ready,
  output logic                auto_in_d_valid,
  output logic [2:0]          auto_in_d_bits_opcode,
  output logic [1:0]          auto_in_d_bits_param,
  output logic [SIZE_W-1:0]   auto_in_d_bits_size,
  output logic [SRC_W-1:0]    auto_in_d_bits_source,
  output logic                auto_in_d_bits_sink,
  output logic                auto_in_d_bits_denied,
  output logic [DATA_W-1:0]   auto_in_d_bits_data,
  output logic                auto_in_d_bits_corrupt,
  // A channel toward downstream
  input  logic                auto_out_a_ready,
  output logic                auto_out_a_valid,
  output logic [2:0]          auto_out_a_bits_opcode,
  output logic [2:0]          auto_out_a_bits_param,
  output logic [SIZE_W-1:0]   auto_out_a_bits_size,
  output logic [SRC_W-1:0]    auto_out_a_bits_source,
  output logic [ADDR_W-1:0]   auto_out_a_bits_address,
  output logic [DATA_W/8-1:0] auto_out_a_bits_mask,
  output logic [DATA_W-1:0]   auto_out_a_bits_data,
  output logic                auto_out_a_bits_corrupt,
  // D channel from downstream
  output logic                auto_out_d_ready,
  input  logic                auto_out_d_valid,
  input  logic [2:0]          auto_out_d_bits_opcode,
  input  logic [1:0]          auto_out_d_bits_param,
  input  logic [SIZE_W-1:0]   auto_out_d_bits_size,
  input  logic [SRC_W-1:0]    auto_out_d_bits_source,
  input  logic                auto_out_d_bits_sink,
  input  logic                auto_out_d_bits_denied,
  input  logic [DATA_W-1:0]   auto_out_d_bits_data,
  input  logic                auto_out_d_bits_corrupt
);
  localparam int A_W = 3 + 3 + SIZE_W + SRC_W + ADDR_W + DATA_W/8 + DATA_W + 1;
  localparam int D_W = 3 + 2 + SIZE_W + SRC_W + 1 + 1 + DATA_W + 1;

  logic [A_W-1:0] w_a_enq_bits;
  logic [A_W-1:0] w_a_deq_bits;
  logic [D_W-1:0] w_d_enq_bits;
  logic [D_W-1:0] w_d_deq_bits;

  assign w_a_enq_bits = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                         auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                         auto_in_a_bits_data, auto_in_a_bits_corrupt};
  assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
          auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
          auto_out_a_bits_data, auto_out_a_bits_corrupt} = w_a_deq_bits;

  assign w_d_enq_bits = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                         auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                         auto_out_d_bits_data, auto_out_d_bits_corrupt};
  assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
          auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
          auto_in_d_bits_data, auto_in_d_bits_corrupt} = w_d_deq_bits;

  tl_ad_fifo #(.W(A_W), .DEPTH(A_DEPTH)) u_a_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_enq_valid (auto_in_a_valid),
    .o_enq_ready (auto_in_a_ready),
    .i_enq_bits  (w_a_enq_bits),
    .o_deq_valid (auto_out_a_valid),
    .i_deq_ready (auto_out_a_ready),
    .o_deq_bits  (w_a_deq_bits)
  );

  tl_ad_fifo #(.W(D_W), .DEPTH(D_DEPTH)) u_d_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_enq_valid (auto_out_d_valid),
    .o_enq_ready (auto_out_d_ready),
    .i_enq_bits  (w_d_enq_bits),
    .o_deq_valid (auto_in_d_valid),
    .i_deq_ready (auto_in_d_ready),
    .o_deq_bits  (w_d_deq_bits)
  );
endmodule

// File: tb/tb_tl_ad_channel_buffer.sv
// Bench for tl_ad_channel_buffer: table of handshake steps, scoreboards on
// both channels, and hand-written reset / streaming / wrap / independence runs.

module tb_tl_ad_channel_buffer;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [2:0]  source;
    logic [30:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [2:0]  source;
    logic        sink;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } d_beat_t;

  typedef struct {
    logic       in_v;
    logic       out_r;
    logic [7:0] dbyte;
    logic       exp_ready;
    logic       exp_valid;
    logic [7:0] exp_byte;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // main instance (depth 2)
  logic    in_a_valid = 1'b0, in_a_ready, out_a_valid, out_a_ready = 1'b0;
  logic    out_d_valid = 1'b0, out_d_ready, in_d_valid, in_d_ready = 1'b0;
  a_beat_t in_a = '0, out_a;
  d_beat_t out_d = '0, in_d;
  // wrap instance (A depth 3)
  logic    in_a3_valid = 1'b0, in_a3_ready, out_a3_valid, out_a3_ready = 1'b0;
  logic    d3_ready_out, d3_valid_out;
  a_beat_t in_a3 = '0, out_a3;
  d_beat_t d3_in = '0, d3_out;

  int n_checks = 0;
  int n_fail   = 0;
  int d_pops   = 0;
  int a3_pops  = 0;
  a_beat_t q_a[$];
  a_beat_t q_a3[$];
  d_beat_t q_d[$];

  tl_ad_channel_buffer u_dut (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(in_a_ready), .auto_in_a_valid(in_a_valid),
    .auto_in_a_bits_opcode(in_a.opcode), .auto_in_a_bits_param(in_a.param),
    .auto_in_a_bits_size(in_a.size), .auto_in_a_bits_source(in_a.source),
    .auto_in_a_bits_address(in_a.address), .auto_in_a_bits_mask(in_a.mask),
    .auto_in_a_bits_data(in_a.data), .auto_in_a_bits_corrupt(in_a.corrupt),
    .auto_in_d_ready(in_d_ready), .auto_in_d_valid(in_d_valid),
    .auto_in_d_bits_opcode(in_d.opcode), .auto_in_d_bits_param(in_d.param),
    .auto_in_d_bits_size(in_d.size), .auto_in_d_bits_source(in_d.source),
    .auto_in_d_bits_sink(in_d.sink), .auto_in_d_bits_denied(in_d.denied),
    .auto_in_d_bits_data(in_d.data), .auto_in_d_bits_corrupt(in_d.corrupt),
    .auto_out_a_ready(out_a_ready), .auto_out_a_valid(out_a_valid),
    .auto_out_a_bits_opcode(out_a.opcode), .auto_out_a_bits_param(out_a.param),
    .auto_out_a_bits_size(out_a.size), .auto_out_a_bits_source(out_a.source),
    .auto_out_a_bits_address(out_a.address), .auto_out_a_bits_mask(out_a.mask),
    .auto_out_a_bits_data(out_a.data), .auto_out_a_bits_corrupt(out_a.corrupt),
    .auto_out_d_ready(out_d_ready), .auto_out_d_valid(out_d_valid),
    .auto_out_d_bits_opcode(out_d.opcode), .auto_out_d_bits_param(out_d.param),
    .auto_out_d_bits_size(out_d.size), .auto_out_d_bits_source(out_d.source),
    .auto_out_d_bits_sink(out_d.sink), .auto_out_d_bits_denied(out_d.denied),
    .auto_out_d_bits_data(out_d.data), .auto_out_d_bits_corrupt(out_d.corrupt)
  );

  tl_ad_channel_buffer #(.A_DEPTH(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(in_a3_ready), .auto_in_a_valid(in_a3_valid),
    .auto_in_a_bits_opcode(in_a3.opcode), .auto_in_a_bits_param(in_a3.param),
    .auto_in_a_bits_size(in_a3.size), .auto_in_a_bits_source(in_a3.source),
    .auto_in_a_bits_address(in_a3.address), .auto_in_a_bits_mask(in_a3.mask),
    .auto_in_a_bits_data(in_a3.data), .auto_in_a_bits_corrupt(in_a3.corrupt),
    .auto_in_d_ready(1'b1), .auto_in_d_valid(d3_valid_out),
    .auto_in_d_bits_opcode(d3_out.opcode), .auto_in_d_bits_param(d3_out.param),
    .auto_in_d_bits_size(d3_out.size), .auto_in_d_bits_source(d3_out.source),
    .auto_in_d_bits_sink(d3_out.sink), .auto_in_d_bits_denied(d3_out.denied),
    .auto_in_d_bits_data(d3_out.data), .auto_in_d_bits_corrupt(d3_out.corrupt),
    .auto_out_a_ready(out_a3_ready), .auto_out_a_valid(out_a3_valid),
    .auto_out_a_bits_opcode(out_a3.opcode), .auto_out_a_bits_param(out_a3.param),
    .auto_out_a_bits_size(out_a3.size), .auto_out_a_bits_source(out_a3.source),
    .auto_out_a_bits_address(out_a3.address), .auto_out_a_bits_mask(out_a3.mask),
    .auto_out_a_bits_data(out_a3.data), .auto_out_a_bits_corrupt(out_a3.corrupt),
    .auto_out_d_ready(d3_ready_out), .auto_out_d_valid(1'b0),
    .auto_out_d_bits_opcode(d3_in.opcode), .auto_out_d_bits_param(d3_in.param),
    .auto_out_d_bits_size(d3_in.size), .auto_out_d_bits_source(d3_in.source),
    .auto_out_d_bits_sink(d3_in.sink), .auto_out_d_bits_denied(d3_in.denied),
    .auto_out_d_bits_data(d3_in.data), .auto_out_d_bits_corrupt(d3_in.corrupt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic a_beat_t mk_a(input int i, input logic [7:0] b);
    a_beat_t t;
    t.opcode  = 3'(i % 8);
    t.param   = 3'(i % 5);
    t.size    = 4'd3;
    t.source  = 3'(i % 8);
    t.address = 31'h0800_0000 + 31'(i * 8);
    t.mask    = 8'(i * 37 + 1);
    t.data    = {8{b}};
    t.corrupt = i[0];
    return t;
  endfunction

  function automatic d_beat_t mk_d(input int i);
    d_beat_t t;
    t.opcode  = 3'd1;
    t.param   = 2'(i % 4);
    t.size    = 4'd6;
    t.source  = 3'(i % 8);
    t.sink    = i[0];
    t.denied  = i[1];
    t.data    = 64'(i);
    t.corrupt = i[2];
    return t;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboards: handshakes are judged on the falling edge, ahead of the rising edge that commits them.
  always @(negedge clock) begin
    if (reset) begin
      if (out_a_valid && out_a_ready) begin
        if (q_a.size() == 0) check("a_unexpected_beat", out_a, '0);
        else check("a_beat", out_a, q_a.pop_front());
      end
      if (in_a_valid && in_a_ready) q_a.push_back(in_a);
      if (in_d_valid && in_d_ready) begin
        d_pops++;
        if (q_d.size() == 0) check("d_unexpected_beat", in_d, '0);
        else check("d_beat", in_d, q_d.pop_front());
      end
      if (out_d_valid && out_d_ready) q_d.push_back(out_d);
      if (out_a3_valid && out_a3_ready) begin
        a3_pops++;
        if (q_a3.size() == 0) check("a3_unexpected_beat", out_a3, '0);
        else check("a3_beat", out_a3, q_a3.pop_front());
      end
      if (in_a3_valid && in_a3_ready) q_a3.push_back(in_a3);
    end
  end

  initial begin
    vec_t    vecs[10];
    a_beat_t get_beat;
    int      bubbles, sent, cyc, stuck;

    vecs[0] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 8'h11};
    vecs[2] = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 8'h11};
    vecs[3] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11};
    vecs[4] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h22};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h33};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[7] = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 8'h00};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h44};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};

    // power-on reset
    #2 reset = 1'b0;
    #1;
    check("rst_out_a_valid", out_a_valid, 0);
    check("rst_in_a_ready", in_a_ready, 1);
    check("rst_in_d_valid", in_d_valid, 0);
    check("rst_out_d_ready", out_d_ready, 1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // handshake table, fill/backpressure ordering 0x11,0x22,0x33
    for (int i = 0; i < 10; i++) begin
      step();
      in_a_valid  = vecs[i].in_v;
      in_a        = mk_a(i, vecs[i].dbyte);
      out_a_ready = vecs[i].out_r;
      @(negedge clock);
      check($sformatf("vec%0d_in_a_ready", i), in_a_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d_out_a_valid", i), out_a_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_out_a_data", i), out_a.data, {8{vecs[i].exp_byte}});
    end

    // single Get beat: latency one cycle, no flow-through
    step();
    get_beat = '{opcode: 3'd4, param: 3'd0, size: 4'd3, source: 3'd5,
                 address: 31'h1000_0040, mask: 8'hFF, data: 64'h0, corrupt: 1'b0};
    in_a = get_beat;
    in_a_valid = 1'b1;
    out_a_ready = 1'b1;
    @(negedge clock);
    check("get_no_flowthrough", out_a_valid, 0);
    step();
    in_a_valid = 1'b0;
    check("get_out_valid", out_a_valid, 1);
    check("get_out_bits", out_a, get_beat);
    check("get_in_ready", in_a_ready, 1);
    step();
    step();

    // streaming: 64 beats, no bubbles
    bubbles = 0;
    for (int i = 0; i <= 64; i++) begin
      step();
      in_a_valid = (i < 64);
      in_a = mk_a(i + 100, 8'(i));
      out_a_ready = 1'b1;
      @(negedge clock);
      if (i >= 1 && !out_a_valid) bubbles++;
      if (i < 64 && !in_a_ready) bubbles++;
    end
    step();
    in_a_valid = 1'b0;
    check("stream_bubbles", bubbles, 0);
    step();
    check("stream_drained", q_a.size(), 0);

    // wrap across depth-3 pointers with random stalls
    sent = 0;
    cyc = 0;
    while (a3_pops < 10 && cyc < 400) begin
      step();
      in_a3_valid = (sent < 10);
      in_a3 = mk_a(sent + 200, 8'(8'hA0 + sent));
      out_a3_ready = ($urandom_range(0, 2) != 0);
      @(negedge clock);
      if (in_a3_valid && in_a3_ready) sent++;
      cyc++;
    end
    step();
    in_a3_valid = 1'b0;
    check("wrap_beat_count", a3_pops, 10);

    // independence: fill A and stall it, then pass an 8-beat D burst
    out_a_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      in_a_valid = 1'b1;
      in_a = mk_a(300 + i, 8'(8'hC0 + i));
    end
    sent = 0;
    cyc = 0;
    stuck = 0;
    while ((sent < 8 || d_pops < 8) && cyc < 300) begin
      step();
      out_d_valid = (sent < 8);
      out_d = mk_d(sent);
      in_d_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (out_d_valid && out_d_ready) sent++;
      if (in_a_ready) stuck++;
      cyc++;
    end
    step();
    out_d_valid = 1'b0;
    check("indep_d_count", d_pops, 8);
    check("indep_a_held_full", stuck, 0);
    check("indep_a_head", out_a, mk_a(300, 8'hC0));

    // drain A, including the beat left waiting upstream
    out_a_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (in_a_valid && in_a_ready) begin
        @(posedge clock);
        #1;
        in_a_valid = 1'b0;
      end
    end
    check("indep_a_drained", q_a.size(), 0);

    // reset with two A beats buffered: discarded, nothing stale afterwards
    out_a_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      in_a_valid = 1'b1;
      in_a = mk_a(400 + i, 8'hEE);
    end
    step();
    in_a_valid = 1'b0;
    check("pre_rst_held_full", in_a_ready, 0);
    #2 reset = 1'b0;
    #1;
    check("midrst_out_a_valid", out_a_valid, 0);
    check("midrst_in_a_ready", in_a_ready, 1);
    q_a.delete();
    @(negedge clock);
    reset = 1'b1;
    out_a_ready = 1'b1;
    repeat (4) step();
    check("post_rst_no_stale", out_a_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
